// File: rtl/doodle_motion_ctrl.sv
// Doodle player physics: horizontal wrap, typed-platform bounce, fall-out damage and death.
// Define DOODLE_WALL_CLAMP_EN to clamp at the field walls instead of wrapping.
module doodle_motion_ctrl #(
    parameter int unsigned N_PLAT        = 8,
    parameter int unsigned W             = 640,
    parameter int unsigned H             = 480,
    parameter int unsigned X_MIN         = 140,
    parameter int unsigned X_MAX         = 499,
    parameter int unsigned SIZE_X        = 32,
    parameter int unsigned SIZE_Y        = 32,
    parameter int unsigned X_STEP        = 3,
    parameter int unsigned GRAVITY       = 1,
    parameter int unsigned VY_MAX        = 4,
    parameter int unsigned JUMP_V        = 4,
    parameter int unsigned SPRING_V      = 12,
    parameter int unsigned HEALTH_INIT   = 10,
    parameter int unsigned INVULN_FRAMES = 128,
    localparam int unsigned IDX_W        = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [1:0]                   frame_clk_edge,
    input  logic [7:0]                   keycode,
    input  logic                         game_active,
    input  logic [N_PLAT-1:0][9:0]       Platform_X,
    input  logic [N_PLAT-1:0][9:0]       Platform_Y,
    input  logic [N_PLAT-1:0][1:0]       Platform_type,
    input  logic [7:0]                   platform_size,
    output logic [9:0]                   Doodle_X_out,
    output logic [9:0]                   Doodle_Y_out,
    output logic [9:0]                   Doodle_VY_out,
    output logic [3:0]                   health,
    output logic                         doodle_facing,
    output logic                         doodle_jumped,
    output logic                         break_req,
    output logic [IDX_W-1:0]             break_idx,
    output logic                         dead
);

    localparam int unsigned CntW = $clog2(INVULN_FRAMES + 1);

    localparam logic signed [10:0] XLeft   = 11'(X_MIN);
    localparam logic signed [10:0] XRight  = 11'(X_MAX - SIZE_X);
    localparam logic signed [10:0] YFall   = 11'(H - 2 - SIZE_Y);
    localparam logic signed [10:0] XStep   = 11'(X_STEP);
    localparam logic signed [10:0] Grav    = 11'(GRAVITY);
    localparam logic signed [10:0] VyMax   = 11'(VY_MAX);
    localparam logic signed [10:0] JumpV   = 11'(JUMP_V);
    localparam logic signed [10:0] SpringV = 11'(SPRING_V);
    localparam logic signed [10:0] SizeY   = 11'(SIZE_Y);
    localparam logic signed [11:0] SizeX12 = 12'(SIZE_X);
    localparam logic signed [11:0] SizeY12 = 12'(SIZE_Y);
    localparam logic [9:0]         XReset  = 10'((W - SIZE_X) / 2);
    localparam logic [9:0]         YReset  = 10'(H * 2 / 3);

    typedef enum logic [1:0] {StAir, StInvuln, StDead} state_e;

    state_e            state_q, state_d;
    logic [9:0]        x_q, y_q;
    logic signed [10:0] vy_q;
    logic [3:0]        health_q, health_d;
    logic              facing_q, facing_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              tick, active;
    logic signed [10:0] x_s, y_s, vx, xn_raw, xn, y_n, vy_n, vy_inc, hit_py;
    logic signed [11:0] xn_w, bot_w, vy_w, psz_w;
    logic [N_PLAT-1:0] hit;
    logic              hit_any, bounce, brk, fall;
    logic [IDX_W-1:0]  hit_idx;
    logic [1:0]        hit_type;

    assign tick   = (frame_clk_edge == 2'b01);
    assign active = tick && !Reset && (state_q != StDead);

    assign x_s   = signed'({1'b0, x_q});
    assign y_s   = signed'({1'b0, y_q});
    assign xn_w  = {xn[10], xn};
    assign bot_w = signed'({2'b00, y_q}) + SizeY12;
    assign vy_w  = {vy_q[10], vy_q};
    assign psz_w = signed'({4'b0000, platform_size});

    // Horizontal move, then wrap or clamp into the field.
    always_comb begin
        vx = 11'sd0;
        if (keycode == 8'h04) begin
            vx = -XStep;
        end else if (keycode == 8'h07) begin
            vx = XStep;
        end
        xn_raw = x_s + vx;
`ifdef DOODLE_WALL_CLAMP_EN
        if (xn_raw > XRight) begin
            xn = XRight;
        end else if (xn_raw < XLeft) begin
            xn = XLeft;
        end else begin
            xn = xn_raw;
        end
`else
        if (xn_raw > XRight) begin
            xn = XLeft;
        end else if (xn_raw < XLeft) begin
            xn = XRight;
        end else begin
            xn = xn_raw;
        end
`endif
        facing_d = facing_q;
        if (vx < 11'sd0) begin
            facing_d = 1'b0;
        end else if (vx > 11'sd0) begin
            facing_d = 1'b1;
        end
    end

    // Per-slot landing test; sums widened so PX + platform_size cannot wrap.
    for (genvar i = 0; i < N_PLAT; i++) begin : g_hit
        logic signed [11:0] px, py;
        assign px = signed'({2'b00, Platform_X[i]});
        assign py = signed'({2'b00, Platform_Y[i]});
        assign hit[i] = (Platform_type[i] != 2'd0) && (vy_q > 11'sd0) &&
                        (xn_w < px + psz_w) && (xn_w + SizeX12 > px) &&
                        (bot_w <= py) && (bot_w + vy_w > py);
    end

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_PLAT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_type = Platform_type[hit_idx];
    assign hit_py   = signed'({1'b0, Platform_Y[hit_idx]});
    assign bounce   = hit_any && ((hit_type == 2'd1) || (hit_type == 2'd2));
    assign brk      = hit_any && (hit_type == 2'd3);
    assign vy_inc   = vy_q + Grav;

    always_comb begin
        if (bounce) begin
            y_n  = hit_py - SizeY;
            vy_n = (hit_type == 2'd2) ? -SpringV : -JumpV;
        end else begin
            y_n  = y_s + vy_q;
            vy_n = (vy_inc > VyMax) ? VyMax : vy_inc;
        end
        if (y_n < 11'sd1) begin
            y_n = 11'sd1;
        end
        fall = (y_n > YFall);
        if (fall) begin
            y_n  = 11'sd2;
            vy_n = 11'sd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StAir: begin
                if (fall && game_active) begin
                    health_d = health_q - 4'd1;
                    if (health_q <= 4'd1) begin
                        state_d = StDead;
                    end else begin
                        state_d = StInvuln;
                        cnt_d   = CntW'(INVULN_FRAMES);
                    end
                end
            end
            StInvuln: begin
                if (cnt_q <= CntW'(1)) begin
                    state_d = StAir;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StAir;
            x_q      <= XReset;
            y_q      <= YReset;
            vy_q     <= 11'sd0;
            health_q <= 4'(HEALTH_INIT);
            facing_q <= 1'b1;
            cnt_q    <= '0;
        end else if (active) begin
            state_q  <= state_d;
            x_q      <= xn[9:0];
            y_q      <= y_n[9:0];
            vy_q     <= vy_n;
            health_q <= health_d;
            facing_q <= facing_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Doodle_X_out  = x_q;
    assign Doodle_Y_out  = y_q;
    assign Doodle_VY_out = vy_q[9:0];
    assign health        = health_q;
    assign doodle_facing = facing_q;
    assign dead          = (state_q == StDead);
    // Pulses are combinational so they cover exactly the tick cycle.
    assign doodle_jumped = active && bounce;
    assign break_req     = active && brk;
    assign break_idx     = break_req ? hit_idx : '0;

endmodule

// File: doc/doodle_motion_ctrl.md
Name:
doodle_motion_ctrl

Overview:
Parametrised player-physics block for the Doodle Jump datapath, and the successor to the fixed 8-platform doodle controller. It generalises platform count and physics constants, adds typed platforms (normal, spring, breakable), landing snap, post-damage invulnerability and a terminal DEAD state. It sits between the keyboard/game-state logic and the sprite renderer and platform manager, and updates once per frame tick.

Parameters:
N_PLAT, 8, number of platform slots
W, 640, screen width
H, 480, screen height
X_MIN, 140, game-field left bound
X_MAX, 499, game-field right bound
SIZE_X, 32, doodle width
SIZE_Y, 32, doodle height
X_STEP, 3, horizontal speed (px/tick)
GRAVITY, 1, vy increment per tick
VY_MAX, 4, terminal fall speed
JUMP_V, 4, bounce speed, normal platform
SPRING_V, 12, bounce speed, spring platform
HEALTH_INIT, 10, starting health (1..15)
INVULN_FRAMES, 128, ticks of damage immunity after a fall-out

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high
frame_clk_edge  in  2  frame edge detector; 2'b01 = update tick
keycode  in  8  8'h04 = left, 8'h07 = right
game_active  in  1  1 = damage enabled
Platform_X  in  N_PLAT x 10  platform left edge
Platform_Y  in  N_PLAT x 10  platform top edge
Platform_type  in  N_PLAT x 2  0 = empty, 1 = normal, 2 = spring, 3 = breakable
platform_size  in  8  platform width
Doodle_X_out  out  10  doodle left edge
Doodle_Y_out  out  10  doodle top edge
Doodle_VY_out  out  10  signed vertical speed
health  out  4  remaining health
doodle_facing  out  1  0 = left, 1 = right
doodle_jumped  out  1  one-Clk pulse on bounce
break_req  out  1  one-Clk pulse when a breakable platform is hit
break_idx  out  $clog2(N_PLAT)  slot of the broken platform, valid with break_req
dead  out  1  high in the DEAD state

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. Reset has priority over a tick in the same cycle, and may be asserted at any time.
- Reset values: X = (W-SIZE_X)/2 = 304, Y = H*2/3 = 320, vy = 0, health = HEALTH_INIT, facing = 1, jumped/break_req/break_idx/dead = 0, state = AIR, invulnerability counter = 0.
- States: AIR, INVULN, DEAD. All registers change only when a tick is present (frame_clk_edge == 2'b01). Pulses are high for exactly the tick cycle.
- Arithmetic: all position and velocity math is 11-bit signed, so there is no unsigned underflow.
- Horizontal:
  - vx = -X_STEP for 8'h04, +X_STEP for 8'h07, otherwise 0; vx is applied in the same tick.
  - xn = X + vx. If xn > X_MAX-SIZE_X then xn = X_MIN; else if xn < X_MIN then xn = X_MAX-SIZE_X.
  - Facing: 0 if vx < 0, 1 if vx > 0, held if vx = 0.
- Collision, slot i hits when all of the following hold:
  - type[i] != 0 and vy > 0;
  - xn < PX[i]+platform_size and xn+SIZE_X > PX[i];
  - Y+SIZE_Y <= PY[i] and Y+SIZE_Y+vy > PY[i].
  - If several slots hit, the lowest index wins.
- Hit response by type:
  - Normal: Y = PY-SIZE_Y, vy = -JUMP_V, doodle_jumped pulses.
  - Spring: Y = PY-SIZE_Y, vy = -SPRING_V, doodle_jumped pulses.
  - Breakable: no bounce. break_req pulses with break_idx = i. Y and vy follow the no-hit rule.
- No hit: Y = Y+vy, vy = min(vy+GRAVITY, VY_MAX).
- Top clamp: if the new Y < 1, Y = 1.
- Fall-out: if the new Y > H-2-SIZE_Y (446), then Y = 2 and vy = 1.
  - In AIR with game_active = 1: health decrements. If health reaches 0, go to DEAD; otherwise go to INVULN with the counter loaded to INVULN_FRAMES.
  - In INVULN, or when game_active = 0: no damage.
- INVULN: physics identical to AIR. The counter decrements every tick; at 0 the state returns to AIR.
- DEAD: all outputs frozen and dead = 1 until Reset.

Optional Feature:
DOODLE_WALL_CLAMP_EN
- Defined: horizontal wrap is replaced by a clamp to [X_MIN, X_MAX-SIZE_X].
- Undefined: wrap-around exactly as described in Behaviour.

Test Plan:
1. Reset held 2 cycles, no ticks -> X=304, Y=320, VY=0, health=10, facing=1, dead=0. Reset asserted together with a tick -> the same values.
2. Slot 0 = (300, 355), type 1, size 60, no keys, 4 ticks -> Y sequence 320, 321, 323, 323; VY=-4 after the 4th tick; doodle_jumped pulses once. Same setup with type 2 -> VY=-12.
3. Same setup with type 3 and slot 5 also type 1 at (300, 355) -> break_req pulses with break_idx=0, no bounce from slot 5.
4. 8'h07 held from X=467 -> X=140 on the next tick, facing=1. 8'h04 from X=140 -> X=467, facing=0. With DOODLE_WALL_CLAMP_EN defined -> X stays at 467 and 140 respectively.
5. game_active=1, no platforms, fall to Y > 446 -> Y=2, VY=1, health=9, state INVULN. The next fall-out within 128 ticks -> health stays 9.
6. HEALTH_INIT=1, one fall-out -> dead=1, outputs frozen over 50 ticks with keys pressed. Then Reset -> values from scenario 1.
